// File: rtl/src2_decode.sv
// Operand-2 decoder: classifies an ARM instruction's second-operand form for src2shift
// and sequences register-file read addresses, adding a cycle for register-shifted forms.
module src2_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [3:0]  ra1,
   output logic [3:0]  ra2,
   output logic        rs_phase,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  opState,
   output logic [23:0] imm24,
   output logic [3:0]  rd,
   output logic        rrx,
   output logic        illegal
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RSREAD = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] field_q, field_d;
   logic [3:0]  op_state_q, op_state_d;
   logic        rrx_q, rrx_d;
   logic        illegal_q, illegal_d;

   logic [3:0]  dec_op_state;
   logic        dec_rrx;
   logic        dec_illegal;
   logic        dec_rs;
   logic        shift_is_rrx;
   logic        accept;

   // The condition field is irrelevant to operand-2 decoding.
   logic        unused_cond;
   assign unused_cond = ^instr[31:28];

   always_comb begin
      dec_op_state = 4'd0;
      dec_rrx      = 1'b0;
      dec_illegal  = 1'b0;
      dec_rs       = 1'b0;
      shift_is_rrx = (instr[6:5] == 2'b11) && (instr[11:7] == 5'd0);
      case (instr[27:26])
         2'b00: begin
            if (instr[25]) begin
               dec_op_state = 4'd0;
            end else if (instr[4]) begin
               dec_op_state = 4'd5 + {2'b00, instr[6:5]};
               dec_rs       = 1'b1;
            end else begin
               dec_op_state = 4'd1 + {2'b00, instr[6:5]};
               dec_rrx      = shift_is_rrx;
            end
         end
         2'b01: begin
            if (!instr[25]) begin
               dec_op_state = 4'd9;
            end else begin
               dec_op_state = 4'd1 + {2'b00, instr[6:5]};
               dec_rrx      = shift_is_rrx;
            end
         end
         2'b10: begin
            dec_op_state = 4'd10;
         end
         default: begin
            dec_op_state = 4'd9;
            dec_illegal  = 1'b1;
         end
      endcase
   end

   // Ready is gated by reset so upstream never sees an accept window while held in reset.
   always_comb begin
      instr_ready = 1'b0;
      if (!reset && !flush) begin
         case (state_q)
            IDLE:    instr_ready = 1'b1;
            OUT:     instr_ready = out_ready;
            default: instr_ready = 1'b0;
         endcase
      end
   end

   assign accept = instr_valid && instr_ready;

   always_comb begin
      state_d    = state_q;
      field_d    = field_q;
      op_state_d = op_state_q;
      rrx_d      = rrx_q;
      illegal_d  = illegal_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = dec_rs ? RSREAD : OUT;
            end
         end
         RSREAD: begin
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               if (accept) begin
                  state_d = dec_rs ? RSREAD : OUT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush) begin
         state_d = IDLE;
      end

      if (accept) begin
         field_d    = instr[23:0];
         op_state_d = dec_op_state;
         rrx_d      = dec_rrx;
         illegal_d  = dec_illegal;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         field_q    <= 24'd0;
         op_state_q <= 4'd0;
         rrx_q      <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         field_q    <= field_d;
         op_state_q <= op_state_d;
         rrx_q      <= rrx_d;
         illegal_q  <= illegal_d;
      end
   end

   assign out_valid = (state_q == OUT);
   assign rs_phase  = (state_q == RSREAD);
   assign ra1       = field_q[19:16];
   assign ra2       = rs_phase ? field_q[11:8] : field_q[3:0];
   assign rd        = field_q[15:12];
   assign imm24     = field_q;
   assign opState   = op_state_q;
   assign rrx       = rrx_q;
   assign illegal   = illegal_q;

endmodule
